// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared state encoding and width helper for the LED shift driver.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Counter width that never collapses to zero bits for degenerate parameters.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_sr_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : led_sr_driver_if
// Description : Load handshake and shift-register chain pins of the LED driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_sr_driver_if #(
    parameter int LED_COUNT = 16
);
    logic [LED_COUNT-1:0] led_data;
    logic                 load_valid;
    logic                 load_ready;
    logic                 sr_data;
    logic                 sr_clk;
    logic                 sr_latch;
    logic                 busy;

    modport master (
        output led_data,
        output load_valid,
        input  load_ready,
        input  sr_data,
        input  sr_clk,
        input  sr_latch,
        input  busy
    );

    modport slave (
        input  led_data,
        input  load_valid,
        output load_ready,
        output sr_data,
        output sr_clk,
        output sr_latch,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/led_sr_tick.sv
`default_nettype none
// ============================================================================
// Module      : led_sr_tick
// Description : Free-running 0..CLK_DIV-1 divider with clear/enable and a
//               terminal-count tick.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sr_tick
    import led_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  clear,
    input  wire  enable,
    output logic tick
);

    localparam int                C_W    = clog2_min1(CLK_DIV);
    localparam logic [C_W-1:0]    C_TERM = C_W'(CLK_DIV - 1);
    localparam logic [C_W-1:0]    C_ONE  = C_W'(1);

    logic [C_W-1:0] r_count;
    logic           w_term;

    assign w_term = (r_count == C_TERM);
    assign tick   = enable && w_term;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_term ? '0 : (r_count + C_ONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_sr_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_sr_driver
// Description : Captures a parallel LED word and shifts it into a 74HC595-style
//               chain, followed by a storage-latch pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sr_driver
    import led_pkg::*;
#(
    parameter int LED_COUNT = 16,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  wire              clk,
    input  wire              rst,
    led_sr_driver_if.slave   bus
);

    localparam int                  C_CNT_W    = clog2_min1(LED_COUNT);
    localparam logic [C_CNT_W-1:0]  C_LAST_BIT = C_CNT_W'(LED_COUNT - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE  = C_CNT_W'(1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LED_COUNT-1:0]   r_shadow;
    logic [LED_COUNT-1:0]   w_shadow_next;
    logic [LED_COUNT-1:0]   w_shadow_adv;
    logic [C_CNT_W-1:0]     r_bit_cnt;
    logic [C_CNT_W-1:0]     w_bit_cnt_next;
    logic                   r_sr_data;
    logic                   w_sr_data_next;
    logic                   r_sr_clk;
    logic                   w_sr_clk_next;
    logic                   r_sr_latch;
    logic                   w_sr_latch_next;
    logic                   r_load_ready;
    logic                   r_busy;
    logic                   w_tick;
    logic                   w_div_clear;
    logic                   w_div_enable;

    // The bit on the wire is always the leading end of the shadow word.
    function automatic logic lead_bit(input logic [LED_COUNT-1:0] word);
        return (MSB_FIRST != 0) ? word[LED_COUNT-1] : word[0];
    endfunction

    assign w_shadow_adv = (MSB_FIRST != 0) ? (r_shadow << 1) : (r_shadow >> 1);
    assign w_div_clear  = (r_state == ST_IDLE);
    assign w_div_enable = (r_state != ST_IDLE);

    led_sr_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_div_clear),
        .enable (w_div_enable),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_next    = r_state;
        w_shadow_next   = r_shadow;
        w_bit_cnt_next  = r_bit_cnt;
        w_sr_data_next  = r_sr_data;
        w_sr_clk_next   = r_sr_clk;
        w_sr_latch_next = r_sr_latch;

        case (r_state)
            ST_IDLE: begin
                if (bus.load_valid && r_load_ready) begin
                    w_state_next   = ST_SHIFT;
                    w_shadow_next  = bus.led_data;
                    w_bit_cnt_next = '0;
                    w_sr_data_next = lead_bit(bus.led_data);
                    w_sr_clk_next  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_sr_clk) begin
                        w_sr_clk_next = 1'b1;
                    end else begin
                        // Falling edge of sr_clk doubles as the bit boundary.
                        w_sr_clk_next = 1'b0;
                        if (r_bit_cnt < C_LAST_BIT) begin
                            w_bit_cnt_next = r_bit_cnt + C_CNT_ONE;
                            w_shadow_next  = w_shadow_adv;
                            w_sr_data_next = lead_bit(w_shadow_adv);
                        end else begin
                            w_state_next    = ST_LATCH;
                            w_sr_data_next  = 1'b0;
                            w_sr_latch_next = 1'b1;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (w_tick) begin
                    w_state_next    = ST_IDLE;
                    w_sr_latch_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shadow     <= '0;
            r_bit_cnt    <= '0;
            r_sr_data    <= 1'b0;
            r_sr_clk     <= 1'b0;
            r_sr_latch   <= 1'b0;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shadow     <= w_shadow_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_sr_data    <= w_sr_data_next;
            r_sr_clk     <= w_sr_clk_next;
            r_sr_latch   <= w_sr_latch_next;
            r_load_ready <= (w_state_next == ST_IDLE);
            r_busy       <= (w_state_next != ST_IDLE);
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.busy       = r_busy;
    assign bus.sr_data    = r_sr_data;
    assign bus.sr_clk     = r_sr_clk;
    assign bus.sr_latch   = r_sr_latch;

endmodule
`default_nettype wire

// File: tb/tb_led_sr_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sr_driver
// Description : Scoreboard bench for led_sr_driver across four configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sr_driver;

    int checks = 0;
    int errors = 0;

    logic        clk;
    logic [3:0]  rst_v;
    logic [3:0]  in_valid;
    logic [15:0] in_data [4];
    logic [3:0]  ready_w, busy_w, data_w, sclk_w, latch_w;
    logic [15:0] exp_q [4][$];

    function automatic int cfg_n(input int i);
        case (i)
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_d(input int i);
        case (i)
            0:       return 4;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_m(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic logic [15:0] mask16(input int i);
        logic [16:0] m;
        m = (17'd1 << cfg_n(i)) - 17'd1;
        return m[15:0];
    endfunction

    // What the 74HC595 chain holds after a frame: first-shifted bit ends up on top.
    function automatic logic [15:0] frame_expect(input int i, input logic [15:0] w);
        logic [15:0] r;
        int n;
        n = cfg_n(i);
        r = '0;
        if (cfg_m(i) != 0) return w & mask16(i);
        for (int k = 0; k < n; k++) r[k] = w[n-1-k];
        return r;
    endfunction

    function automatic logic [4:0] outs(input int i);
        return {ready_w[i], busy_w[i], data_w[i], sclk_w[i], latch_w[i]};
    endfunction

    led_sr_driver_if #(.LED_COUNT(16)) bus0 ();
    led_sr_driver_if #(.LED_COUNT(8))  bus1 ();
    led_sr_driver_if #(.LED_COUNT(16)) bus2 ();
    led_sr_driver_if #(.LED_COUNT(16)) bus3 ();

    led_sr_driver #(.LED_COUNT(16), .CLK_DIV(4), .MSB_FIRST(1)) u_dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
    led_sr_driver #(.LED_COUNT(8),  .CLK_DIV(1), .MSB_FIRST(0)) u_dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));
    led_sr_driver #(.LED_COUNT(16), .CLK_DIV(1), .MSB_FIRST(1)) u_dut2 (.clk(clk), .rst(rst_v[2]), .bus(bus2));
    led_sr_driver #(.LED_COUNT(16), .CLK_DIV(3), .MSB_FIRST(1)) u_dut3 (.clk(clk), .rst(rst_v[3]), .bus(bus3));

    assign bus0.led_data   = in_data[0];
    assign bus1.led_data   = in_data[1][7:0];
    assign bus2.led_data   = in_data[2];
    assign bus3.led_data   = in_data[3];
    assign bus0.load_valid = in_valid[0];
    assign bus1.load_valid = in_valid[1];
    assign bus2.load_valid = in_valid[2];
    assign bus3.load_valid = in_valid[3];
    assign ready_w = {bus3.load_ready, bus2.load_ready, bus1.load_ready, bus0.load_ready};
    assign busy_w  = {bus3.busy,       bus2.busy,       bus1.busy,       bus0.busy};
    assign data_w  = {bus3.sr_data,    bus2.sr_data,    bus1.sr_data,    bus0.sr_data};
    assign sclk_w  = {bus3.sr_clk,     bus2.sr_clk,     bus1.sr_clk,     bus0.sr_clk};
    assign latch_w = {bus3.sr_latch,   bus2.sr_latch,   bus1.sr_latch,   bus0.sr_latch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic idle_check(input int i, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            check("idle_outputs", i, 32'(outs(i)), 32'h10);
        end
    endtask

    // Frames accepted back to back from the calling cycle; cycle k after the
    // first accept edge is checked against the frame period arithmetic.
    task automatic timing_run(input int i, input logic [15:0] w1, input logic [15:0] w2,
                              input int nframes, input int kmax);
        int  n, d, p, f, r;
        logic exp_latch, exp_ready;
        n = cfg_n(i);
        d = cfg_d(i);
        p = 2 * d * n + d + 1;
        exp_q[i].push_back(w1 & mask16(i));
        if (nframes > 1) exp_q[i].push_back(w2 & mask16(i));
        in_data[i]  = w1;
        in_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        in_data[i] = (nframes > 1) ? w2 : ~w1;
        for (int k = 1; k <= kmax; k++) begin
            if (k - 1 == (nframes - 1) * p) in_valid[i] = 1'b0;
            f = k / p;
            r = k % p;
            exp_ready = (f >= nframes) || (r == 0);
            exp_latch = (f < nframes) && (r >= 2 * d * n + 1) && (r <= 2 * d * n + d);
            @(negedge clk);
            check("frame_timing", i, {29'd0, latch_w[i], ready_w[i], busy_w[i]},
                  {29'd0, exp_latch, exp_ready, !exp_ready});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_abort_test();
        logic [15:0] w;
        w = 16'($urandom);
        exp_q[0].push_back(w);
        in_data[0]  = w;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (39) begin
            @(posedge clk);
            #1;
        end
        rst_v[0] = 1'b1;
        void'(exp_q[0].pop_back());
        @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("reset_abort", 0, 32'(outs(0)), 32'h10);
        idle_check(0, 10);
        timing_run(0, 16'($urandom), 16'h0000, 1, 140);
    endtask

    task automatic random_phase(input int i, input int quota);
        int   n, d, p, e, next_ok, acc, guard;
        logic exp_ready;
        n = cfg_n(i);
        d = cfg_d(i);
        p = 2 * d * n + d + 1;
        e = 0; next_ok = 0; acc = 0; guard = 0;
        while (acc < quota && guard < 30000) begin
            in_valid[i] = ($urandom_range(0, 5) == 0);
            in_data[i]  = 16'($urandom) & mask16(i);
            exp_ready   = (e >= next_ok);
            @(negedge clk);
            check("ready_busy", i, {30'd0, ready_w[i], busy_w[i]}, {30'd0, exp_ready, !exp_ready});
            @(posedge clk);
            if (in_valid[i] && exp_ready) begin
                exp_q[i].push_back(in_data[i]);
                next_ok = e + p;
                acc++;
            end
            e++;
            guard++;
            #1;
        end
        in_valid[i] = 1'b0;
        check("random_quota", i, 32'(acc), 32'(quota));
        repeat (p + 5) @(posedge clk);
        #1;
    endtask

    // Monitor: models the external chain and checks each latch pulse.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mon
        localparam int N = cfg_n(gi);
        localparam int D = cfg_d(gi);
        initial begin
            logic [15:0] chain, word;
            int          rises, stab, lwidth;
            logic        pclk, platch, pdata;
            chain = '0; rises = 0; stab = 0; lwidth = 0;
            pclk = 1'b0; platch = 1'b0; pdata = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_v[gi]) begin
                    rises = 0; stab = 0; lwidth = 0;
                    pclk = 1'b0; platch = 1'b0; pdata = 1'b0;
                end else begin
                    stab = (data_w[gi] == pdata) ? stab + 1 : 1;
                    if (sclk_w[gi] && !pclk) begin
                        check("data_setup", gi, 32'(stab > D), 32'd1);
                        chain = {chain[14:0], data_w[gi]};
                        rises++;
                    end
                    if (latch_w[gi]) check("clk_low_in_latch", gi, 32'(sclk_w[gi]), 32'd0);
                    if (latch_w[gi] && !platch) begin
                        check("rises_per_frame", gi, 32'(rises), 32'(N));
                        if (exp_q[gi].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_latch dut%0d: got latch pulse, expected none at %0t", gi, $time);
                        end else begin
                            word = exp_q[gi].pop_front();
                            check("latched_word", gi, 32'(chain & mask16(gi)), 32'(frame_expect(gi, word)));
                        end
                        rises  = 0;
                        lwidth = 0;
                    end
                    if (latch_w[gi]) lwidth++;
                    if (!latch_w[gi] && platch) check("latch_width", gi, 32'(lwidth), 32'(D));
                    pclk   = sclk_w[gi];
                    platch = latch_w[gi];
                    pdata  = data_w[gi];
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_v    = 4'hF;
        in_valid = 4'h0;
        for (int i = 0; i < 4; i++) in_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_v = 4'h0;
        fork
            begin
                idle_check(0, 20);
                timing_run(0, 16'hA5C3, 16'h0000, 1, 140);
                timing_run(0, 16'hFFFF, 16'h0001, 2, 270);
                reset_abort_test();
                random_phase(0, 60);
            end
            begin
                timing_run(1, 16'h0001, 16'h0000, 1, 20);
                random_phase(1, 40);
            end
            random_phase(2, 50);
            random_phase(3, 50);
        join
        repeat (5) @(posedge clk);
        for (int i = 0; i < 4; i++) check("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_sr_driver.md
Name: led_sr_driver

Overview:
- Consumes the parallel LED word from the counter/pattern stage and shifts it serially into an external 74HC595-style shift-register chain.
- Generates the serial data, shift clock and storage-latch strobe.
- Sits between the LED pattern source and the board pins.
- Uses a valid/ready load handshake so the upstream word is captured atomically once per frame.

Parameters:
- LED_COUNT, 16, number of LEDs (bits per frame); must be >= 1.
- CLK_DIV, 4, clk cycles per half-period of sr_clk and width of the sr_latch pulse; must be >= 1.
- MSB_FIRST, 1, 1 = led_data[LED_COUNT-1] shifted first; 0 = led_data[0] first.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- led_data, input, LED_COUNT, LED pattern word from upstream.
- load_valid, input, 1, upstream offers led_data.
- load_ready, output, 1, block can accept a word (high only in IDLE).
- sr_data, output, 1, serial data to the chain (SER).
- sr_clk, output, 1, shift clock to the chain (SRCLK); the chain samples sr_data on its rising edge.
- sr_latch, output, 1, storage latch strobe to the chain (RCLK); active-high pulse.
- busy, output, 1, high while in SHIFT or LATCH.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE, load_ready=1, busy=0.
  - sr_data=0, sr_clk=0, sr_latch=0.
  - shadow register=0, bit counter=0, divider=0.
- rst dominates load_valid in the same cycle; no capture occurs.
- All outputs are registered, with no combinational path from inputs to outputs.
- Handshake:
  - A transfer occurs on an edge where load_valid && load_ready.
  - led_data is captured into the shadow register on that edge.
  - led_data changes afterwards do not affect the current frame.
  - load_valid while busy is ignored; it is not queued.
- Divider:
  - Counts 0..CLK_DIV-1 and emits a tick on the terminal count.
  - Held at 0 in IDLE.
- FSM:
  - IDLE:
    - load_ready=1.
    - On transfer, go to SHIFT: load shadow, bit counter=0, drive sr_data with the first bit, sr_clk=0.
  - SHIFT, each bit occupies 2*CLK_DIV cycles:
    - CLK_DIV cycles with sr_clk=0, then CLK_DIV cycles with sr_clk=1.
    - sr_data is stable for the whole bit period, including the sr_clk rise.
    - On the tick ending the high phase: sr_clk goes 0.
    - If the bit counter is below LED_COUNT-1: increment it and present the next bit on the same edge.
    - Otherwise: go to LATCH with sr_data=0.
  - LATCH:
    - sr_latch=1 for exactly CLK_DIV cycles, then IDLE.
    - sr_clk=0 throughout.
- Latency:
  - Transfer edge T.
  - First sr_data valid at T+1; first sr_clk rise at T+1+CLK_DIV.
  - sr_latch high from T+1+2*CLK_DIV*LED_COUNT for CLK_DIV cycles.
  - load_ready high again at T+1+2*CLK_DIV*LED_COUNT+CLK_DIV. With defaults: T+133.
  - Back-to-back transfer is possible on that cycle, giving a frame period of 2*CLK_DIV*LED_COUNT+CLK_DIV+1 cycles.
- Bit order:
  - MSB_FIRST=1: bit k of the frame is led_data[LED_COUNT-1-k].
  - MSB_FIRST=0: bit k is led_data[k].
- Widths:
  - Bit counter is $clog2(LED_COUNT) bits, minimum 1; divider is $clog2(CLK_DIV) bits, minimum 1.
  - Both wrap-free: they are reset, never rolled past the terminal value.
- Exactly LED_COUNT sr_clk rising edges per frame, then exactly one sr_latch pulse.
- Reset mid-frame:
  - Aborts immediately to reset values; no latch pulse is issued.
  - External LEDs keep the previously latched pattern.
- LED_COUNT=1 and CLK_DIV=1 are legal. With CLK_DIV=1, sr_clk toggles every cycle.

Decomposition:
- Shared package led_pkg:
  - State encoding constants ST_IDLE, ST_SHIFT, ST_LATCH (2-bit).
  - A clog2-with-minimum-1 helper function.
- One sub-module, led_sr_tick: parameterised CLK_DIV divider with synchronous clear and enable, output tick.
- FSM, shadow register and bit counter stay in led_sr_driver.

Test Plan:
- Reset, then idle 20 cycles -> load_ready=1, busy=0, sr_clk/sr_latch/sr_data=0 throughout.
- Defaults, led_data=16'hA5C3, load_valid pulsed 1 cycle at T:
  - 16 sr_clk rises.
  - Sampled bits read 1010_0101_1100_0011 in order.
  - sr_latch high cycles T+129..T+132.
  - load_ready high at T+133.
- load_valid held high with led_data=16'hFFFF, then 16'h0001 from T+1 -> frame shifts FFFF; a second frame starts at T+133 with 0001; period 133 cycles.
- MSB_FIRST=0, LED_COUNT=8, CLK_DIV=1, led_data=8'h01 -> first sampled bit 1, remaining seven 0; sr_latch 1 cycle; load_ready back at T+18.
- rst asserted at T+40 mid-frame -> the next cycle shows all outputs at reset values, no sr_latch pulse, load_ready=1; a new frame after release completes normally.
- Scoreboard model over 200 random words and random load_valid gaps, CLK_DIV in {1,3,4}:
  - Reconstructed latched word equals the accepted word.
  - sr_data never changes within CLK_DIV cycles before any sr_clk rise.
